// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full-subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of one bit position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor behind a Start/Done handshake.
// One full_subtractor cell is reused for W cycles; results and flags are
// only published on the final bit so the outputs never show partial values.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [W-1:0] INa,
  input  logic [W-1:0] INb,
  input  logic         BorrowIn,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Diff,
  output logic         BorrowOut,
  output logic         Overflow,
  output logic         Zero
);

  localparam int CW = $clog2(W + 1);

  state_t         state;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   diff_sh;
  logic           borrow;
  logic [CW-1:0]  count;

  logic           cell_d;
  logic           cell_bout;
  logic           last_bit;
  logic [W-1:0]   diff_next;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Final-bit detect and the result word as it will look after this bit
  always_comb begin
    last_bit  = (count == CW'(W - 1));
    diff_next = {cell_d, diff_sh[W-1:1]};
  end

  // Control FSM with datapath shift registers and registered result/flag outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      diff_sh   <= '0;
      borrow    <= 1'b0;
      count     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Diff      <= '0;
      BorrowOut <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sh   <= INa;
            b_sh   <= INb;
            borrow <= BorrowIn;
            count  <= '0;
            Busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          diff_sh <= diff_next;
          borrow  <= cell_bout;
          count   <= count + CW'(1);
          if (last_bit) begin
            Diff      <= diff_next;
            BorrowOut <= cell_bout;
            Overflow  <= (a_sh[0] != b_sh[0]) & (cell_d != a_sh[0]);
            Zero      <= (diff_next == '0);
            Done      <= 1'b1;
            Busy      <= 1'b0;
            state     <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
